// File: rtl/instr_encoder.sv
// RV32I-subset instruction encoder: packs symbolic requests into 32-bit words and
// queues {word, address} in a small FIFO. Define ENC_RANGE_CHECK_EN to reject out-of-range immediates.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  in_op_i,
  input  logic [4:0]  in_rd_i,
  input  logic [4:0]  in_rs1_i,
  input  logic [4:0]  in_rs2_i,
  input  logic [31:0] in_imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtJ, FmtU} fmt_e;

  logic [63:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d, remaining;
  logic [31:0]     addr_q;
  logic [63:0]     head_q, head_d;
  logic            err_q;
  logic [7:0]      err_cnt_q;

  fmt_e        fmt;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        op_legal, imm_ok;
  logic [31:0] instr;
  logic        accept, push, pop, reject;

  always_comb begin
    fmt      = FmtR;
    opcode   = 7'b0000000;
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    op_legal = 1'b1;
    case (in_op_i)
      4'd0:    begin fmt = FmtI; opcode = 7'b0010011; end
      4'd1:    begin fmt = FmtR; opcode = 7'b0110011; end
      4'd2:    begin fmt = FmtR; opcode = 7'b0110011; funct7 = 7'b0100000; end
      4'd3:    begin fmt = FmtI; opcode = 7'b0000011; funct3 = 3'b010; end
      4'd4:    begin fmt = FmtS; opcode = 7'b0100011; funct3 = 3'b010; end
      4'd5:    begin fmt = FmtB; opcode = 7'b1100011; end
      4'd6:    begin fmt = FmtJ; opcode = 7'b1101111; end
      4'd7:    begin fmt = FmtI; opcode = 7'b1100111; end
      4'd8:    begin fmt = FmtU; opcode = 7'b0110111; end
      4'd9:    begin fmt = FmtU; opcode = 7'b0010111; end
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    instr = 32'h0;
    case (fmt)
      FmtR: instr = {funct7, in_rs2_i, in_rs1_i, funct3, in_rd_i, opcode};
      FmtI: instr = {in_imm_i[11:0], in_rs1_i, funct3, in_rd_i, opcode};
      FmtS: instr = {in_imm_i[11:5], in_rs2_i, in_rs1_i, funct3, in_imm_i[4:0], opcode};
      FmtB: instr = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, funct3,
                     in_imm_i[4:1], in_imm_i[11], opcode};
      FmtJ: instr = {in_imm_i[20], in_imm_i[10:1], in_imm_i[11], in_imm_i[19:12],
                     in_rd_i, opcode};
      FmtU: instr = {in_imm_i[31:12], in_rd_i, opcode};
      default: instr = 32'h0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Sign-extension checks: the dropped upper bits must all equal the top kept bit.
  always_comb begin
    imm_ok = 1'b1;
    case (fmt)
      FmtI, FmtS: imm_ok = (&in_imm_i[31:11]) | ~(|in_imm_i[31:11]);
      FmtB: imm_ok = ((&in_imm_i[31:12]) | ~(|in_imm_i[31:12])) & ~in_imm_i[0];
      FmtJ: imm_ok = ((&in_imm_i[31:20]) | ~(|in_imm_i[31:20])) & ~in_imm_i[0];
      FmtU: imm_ok = ~(|in_imm_i[11:0]);
      default: imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign in_ready_o = (count_q < CntW'(DEPTH));
  assign accept     = in_valid_i & in_ready_o;
  assign push       = accept & op_legal & imm_ok;
  assign reject     = accept & ~(op_legal & imm_ok);
  assign pop        = out_valid_o & out_ready_i;

  // Head is registered so the output holds its last value once the FIFO drains.
  always_comb begin
    rd_ptr_d  = rd_ptr_q + PtrW'(pop);
    remaining = count_q - CntW'(pop);
    count_d   = remaining + CntW'(push);
    head_d    = head_q;
    if (remaining != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (push) begin
      head_d = {instr, addr_q};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 64'h0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= BASE_ADDR;
      head_q    <= 64'h0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {instr, addr_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        addr_q          <= addr_q + 32'd4;
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      err_q    <= reject;
      if (reject && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign out_valid_o = (count_q != '0);
  assign out_instr_o = head_q[63:32];
  assign out_addr_o  = head_q[31:0];
  assign err_o       = err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
